// File: rtl/i2c_byte_master_if.sv
// i2c_byte_master_if: command handshake, status flags and open-drain bus lines of the
// byte-level I2C master. The master modport is the controller's view; the slave modport
// is the view of whatever issues commands and models the bus.
interface i2c_byte_master_if;
    logic [2:0] cmd_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] wr_data_i;
    logic       done_o;
    logic [7:0] rd_data_o;
    logic       ack_o;
    logic       arb_lost_o;
    logic       err_o;
    logic       bus_busy_o;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  cmd_i, cmd_valid_i, wr_data_i, scl_i, sda_i,
        output cmd_ready_o, done_o, rd_data_o, ack_o, arb_lost_o, err_o, bus_busy_o,
        output scl_o, sda_o
    );

    modport slave (
        output cmd_i, cmd_valid_i, wr_data_i, scl_i, sda_i,
        input  cmd_ready_o, done_o, rd_data_o, ack_o, arb_lost_o, err_o, bus_busy_o,
        input  scl_o, sda_o
    );
endinterface

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master executing START / STOP / WRITE / READ_ACK / READ_NAK
// commands. Every bus phase is four quarters of CLK_DIV clocks each; SCL/SDA are registered
// open-drain drives (0 pulls low, 1 releases).
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch SCL in the high quarter.
module i2c_byte_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input logic               clk_i,
    input logic               rst_n_i,
    i2c_byte_master_if.master bus
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StBit   = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [2:0] CmdStart   = 3'b000;
    localparam logic [2:0] CmdStop    = 3'b001;
    localparam logic [2:0] CmdWrite   = 3'b010;
    localparam logic [2:0] CmdReadAck = 3'b011;
    localparam logic [2:0] CmdReadNak = 3'b100;

    logic [2:0]    state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    op_q, op_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          arb_q, arb_d;
    logic          err_q, err_d;
    logic [7:0]    rd_q, rd_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;

    logic cmd_ready;
    logic stretch;
    logic sample;
    logic load;     // a new quarter starts next cycle: recompute the line drive
    logic bit_val;  // SDA level for the data bit being entered

    assign cmd_ready = (state_q == StIdle) && rst_n_i;

`ifdef I2C_CLK_STRETCH_EN
    // SCL is released in Q1 of every phase; a low scl_i there means a slave is holding it.
    assign stretch = ((state_q == StStart) || (state_q == StBit) || (state_q == StStop)) &&
                     (qtr_q == 2'd1) && !bus.scl_i;
`else
    assign stretch = 1'b0;
`endif

    assign sample = (state_q == StBit) && (qtr_q == 2'd1) && (cnt_q == CntLast) && !stretch;

    // Next-state: command acceptance, quarter sequencing, sampling and line drive.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        op_d    = op_q;
        busy_d  = busy_q;
        ack_d   = ack_q;
        arb_d   = arb_q;
        err_d   = err_q;
        rd_d    = rd_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        load    = 1'b0;
        bit_val = 1'b1;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid_i && cmd_ready) begin
                    ack_d   = 1'b0;
                    arb_d   = 1'b0;
                    err_d   = 1'b0;
                    op_d    = bus.cmd_i;
                    shreg_d = bus.wr_data_i;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 4'd0;
                    load    = 1'b1;
                    case (bus.cmd_i)
                        CmdStart:                         state_d = StStart;
                        CmdStop:                          state_d = busy_q ? StStop : StDone;
                        CmdWrite, CmdReadAck, CmdReadNak: state_d = busy_q ? StBit : StDone;
                        default:                          state_d = StDone;
                    endcase
                    // Rejected commands finish at once and leave the bus alone.
                    if (state_d == StDone) begin
                        err_d = 1'b1;
                        load  = 1'b0;
                    end
                end
            end
            StStart, StBit, StStop: begin
                if (stretch) begin
                    cnt_d = '0;
                end else if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    qtr_d = qtr_q + 2'd1;
                    load  = 1'b1;
                    if (qtr_q == 2'd3) begin
                        if (state_q == StStart) begin
                            busy_d  = 1'b1;
                            state_d = StDone;
                            load    = 1'b0;
                        end else if (state_q == StStop) begin
                            busy_d  = 1'b0;
                            state_d = StDone;
                            load    = 1'b0;
                        end else if (bit_q == 4'd8) begin
                            state_d = StDone;
                            load    = 1'b0;
                            if (op_q != CmdWrite) rd_d = shreg_q;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                if (sample) begin
                    if (bit_q != 4'd8) begin
                        shreg_d = {shreg_q[6:0], bus.sda_i};
                        // Released data bit read back low: another master owns the bus.
                        if ((op_q == CmdWrite) && sda_q && !bus.sda_i) begin
                            arb_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StDone;
                            load    = 1'b0;
                            scl_d   = 1'b1;
                            sda_d   = 1'b1;
                        end
                    end else if (op_q == CmdWrite) begin
                        ack_d = ~bus.sda_i;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bit_d == 4'd8) begin
            bit_val = (op_d == CmdReadAck) ? 1'b0 : 1'b1;
        end else begin
            bit_val = (op_d == CmdWrite) ? shreg_d[7] : 1'b1;
        end

        if (load) begin
            case (state_d)
                StStart: begin
                    case (qtr_d)
                        2'd0:    sda_d = 1'b1;
                        2'd1:    scl_d = 1'b1;
                        2'd2:    sda_d = 1'b0;
                        default: scl_d = 1'b0;
                    endcase
                end
                StBit: begin
                    scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                    if (qtr_d == 2'd0) sda_d = bit_val;
                end
                StStop: begin
                    case (qtr_d)
                        2'd0: begin
                            scl_d = 1'b0;
                            sda_d = 1'b0;
                        end
                        2'd1:    scl_d = 1'b1;
                        2'd3:    sda_d = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset releases both lines.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            qtr_q   <= 2'd0;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= 8'h00;
            op_q    <= CmdStart;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            arb_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 8'h00;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            arb_q   <= arb_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.done_o      = (state_q == StDone);
    assign bus.rd_data_o   = rd_q;
    assign bus.ack_o       = ack_q;
    assign bus.arb_lost_o  = arb_q;
    assign bus.err_o       = err_q;
    assign bus.bus_busy_o  = busy_q;
    assign bus.scl_o       = scl_q;
    assign bus.sda_o       = sda_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed bench for i2c_byte_master with CLK_DIV=4, a simple slave
// model (ACK / read-byte / silent), an external SDA puller and an SCL stretcher.
`timescale 1ns/1ps
module tb_i2c_byte_master;
    localparam int unsigned CLK_DIV = 4;
    localparam int PH = 4 * CLK_DIV;   // cycles per START/STOP phase
    localparam int BY = 36 * CLK_DIV;  // cycles per byte command

    localparam logic [2:0] CmdStart   = 3'b000;
    localparam logic [2:0] CmdStop    = 3'b001;
    localparam logic [2:0] CmdWrite   = 3'b010;
    localparam logic [2:0] CmdReadNak = 3'b100;

    localparam int ModeIdle = 0;
    localparam int ModeAck  = 1;
    localparam int ModeRead = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        slave_scl = 1'b1;
    logic        ext_sda = 1'b1;
    logic        slave_sda;
    int          mode = ModeIdle;
    logic [7:0]  slave_byte = 8'h00;
    logic        scl_seen = 1'b1;
    int          rise_cnt = 0;
    logic [15:0] rise_sh = 16'h0;

    i2c_byte_master_if bif ();

    i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bif.master)
    );

    assign bif.scl_i = bif.scl_o & slave_scl;
    assign bif.sda_i = bif.sda_o & slave_sda & ext_sda;

    // Slave data: bit index is the number of SCL rises seen, minus one while SCL is high.
    always_comb begin
        int idx;
        idx = scl_seen ? rise_cnt - 1 : rise_cnt;
        slave_sda = 1'b1;
        if (mode == ModeAck && idx == 8) slave_sda = 1'b0;
        if (mode == ModeRead && idx >= 0 && idx < 8) slave_sda = slave_byte[3'(7 - idx)];
    end

    // Records resolved SDA at every SCL rise; cleared when a command is accepted.
    always @(posedge clk) begin
        scl_seen <= bif.scl_o;
        if (bif.cmd_valid_i && bif.cmd_ready_o) begin
            rise_cnt <= 0;
            rise_sh  <= 16'h0;
        end else if (bif.scl_o && !scl_seen) begin
            rise_cnt <= rise_cnt + 1;
            rise_sh  <= {rise_sh[14:0], bif.sda_i};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one command; returns on the negedge right after the accepting edge.
    task automatic issue(input logic [2:0] cmd, input logic [7:0] data);
        int n;
        n = 0;
        while (!bif.cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        bif.cmd_i = cmd;
        bif.wr_data_i = data;
        bif.cmd_valid_i = 1'b1;
        @(negedge clk);
        bif.cmd_valid_i = 1'b0;
    endtask

    // Cycles from acceptance until done_o (0 = first cycle after the accepting edge).
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int k = 0; k <= 2000; k++) begin
            if (bif.done_o) begin
                cycles = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bif.scl_o, bif.sda_o, bif.cmd_ready_o, bif.done_o, bif.ack_o, bif.arb_lost_o,
             bif.err_o, bif.bus_busy_o} !== 8'b1100_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 11000000", {bif.scl_o, bif.sda_o,
                     bif.cmd_ready_o, bif.done_o, bif.ack_o, bif.arb_lost_o, bif.err_o,
                     bif.bus_busy_o});
        end
        checks++;
        if (bif.rd_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data: got %h want 00", bif.rd_data_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after: got %b want 1", bif.cmd_ready_o);
        end
    endtask

    task automatic test_error();
        logic [2:0] codes [2];
        codes[0] = CmdWrite;
        codes[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            issue(codes[i], 8'h12);
            checks++;
            if ({bif.done_o, bif.err_o, bif.arb_lost_o, bif.ack_o} !== 4'b1100) begin
                failures++;
                $display("FAIL err_done code=%b: got done/err/arb/ack=%b want 1100", codes[i],
                         {bif.done_o, bif.err_o, bif.arb_lost_o, bif.ack_o});
            end
            checks++;
            if ({bif.scl_o, bif.sda_o, bif.bus_busy_o} !== 3'b110) begin
                failures++;
                $display("FAIL err_lines code=%b: got scl/sda/busy=%b want 110", codes[i],
                         {bif.scl_o, bif.sda_o, bif.bus_busy_o});
            end
            @(negedge clk);
            checks++;
            if ({bif.done_o, bif.cmd_ready_o, bif.err_o} !== 3'b011) begin
                failures++;
                $display("FAIL err_pulse code=%b: got done/ready/err=%b want 011", codes[i],
                         {bif.done_o, bif.cmd_ready_o, bif.err_o});
            end
        end
    endtask

    task automatic test_start();
        int c;
        mode = ModeIdle;
        issue(CmdStart, 8'h00);
        wait_done(c);
        checks++;
        if (c !== PH || {bif.bus_busy_o, bif.scl_o, bif.sda_o, bif.err_o} !== 4'b1000) begin
            failures++;
            $display("FAIL start: got cycles=%0d busy/scl/sda/err=%b want %0d 1000", c,
                     {bif.bus_busy_o, bif.scl_o, bif.sda_o, bif.err_o}, PH);
        end
    endtask

    task automatic test_stop();
        int c;
        mode = ModeIdle;
        issue(CmdStop, 8'h00);
        wait_done(c);
        checks++;
        if (c !== PH || {bif.bus_busy_o, bif.scl_o, bif.sda_o, bif.err_o} !== 4'b0110) begin
            failures++;
            $display("FAIL stop: got cycles=%0d busy/scl/sda/err=%b want %0d 0110", c,
                     {bif.bus_busy_o, bif.scl_o, bif.sda_o, bif.err_o}, PH);
        end
    endtask

    task automatic test_write(input logic [7:0] data, input logic acked);
        int c;
        mode = acked ? ModeAck : ModeIdle;
        issue(CmdWrite, data);
        wait_done(c);
        checks++;
        if (c !== BY) begin
            failures++;
            $display("FAIL write_time %h: got %0d want %0d", data, c, BY);
        end
        checks++;
        if ({bif.ack_o, bif.err_o, bif.arb_lost_o} !== {acked, 2'b00}) begin
            failures++;
            $display("FAIL write_status %h: got ack/err/arb=%b want %b", data,
                     {bif.ack_o, bif.err_o, bif.arb_lost_o}, {acked, 2'b00});
        end
        checks++;
        if (rise_cnt !== 9 || rise_sh[8:0] !== {data, ~acked}) begin
            failures++;
            $display("FAIL write_bits %h: got rises=%0d bits=%b want 9 %b", data, rise_cnt,
                     rise_sh[8:0], {data, ~acked});
        end
    endtask

    task automatic test_addr_write();
        test_start();
        test_write(8'h44, 1'b1);
        test_write(8'hA5, 1'b1);
        test_stop();
    endtask

    task automatic test_nack();
        test_start();
        test_write(8'h46, 1'b0);
        test_stop();
    endtask

    task automatic test_read();
        int c;
        test_start();
        test_write(8'h45, 1'b1);
        mode = ModeRead;
        slave_byte = 8'h3C;
        issue(CmdReadNak, 8'h00);
        wait_done(c);
        checks++;
        if (c !== BY || bif.rd_data_o !== 8'h3C || bif.err_o !== 1'b0) begin
            failures++;
            $display("FAIL read: got cycles=%0d rd=%h err=%b want %0d 3c 0", c, bif.rd_data_o,
                     bif.err_o, BY);
        end
        checks++;
        if (rise_sh[8:0] !== {8'h3C, 1'b1}) begin
            failures++;
            $display("FAIL read_bits: got %b want %b", rise_sh[8:0], {8'h3C, 1'b1});
        end
        test_stop();
        checks++;
        if (bif.rd_data_o !== 8'h3C) begin
            failures++;
            $display("FAIL read_hold: got %h want 3c", bif.rd_data_o);
        end
    endtask

    task automatic test_arb();
        int c;
        test_start();
        mode = ModeIdle;
        issue(CmdWrite, 8'hFF);
        c = -1;
        for (int k = 0; k <= 500; k++) begin
            if (k == 33) ext_sda = 1'b0;
            if (bif.done_o) begin
                c = k;
                break;
            end
            @(negedge clk);
        end
        ext_sda = 1'b1;
        checks++;
        if (c !== 40) begin
            failures++;
            $display("FAIL arb_time: got %0d want 40", c);
        end
        checks++;
        if ({bif.arb_lost_o, bif.err_o, bif.bus_busy_o, bif.scl_o, bif.sda_o} !== 5'b10011)
        begin
            failures++;
            $display("FAIL arb_state: got arb/err/busy/scl/sda=%b want 10011",
                     {bif.arb_lost_o, bif.err_o, bif.bus_busy_o, bif.scl_o, bif.sda_o});
        end
    endtask

    task automatic test_stretch();
        int c;
        int exp_c;
`ifdef I2C_CLK_STRETCH_EN
        exp_c = BY + 50;
`else
        exp_c = BY;
`endif
        test_start();
        checks++;
        if (bif.arb_lost_o !== 1'b0) begin
            failures++;
            $display("FAIL arb_cleared: got %b want 0", bif.arb_lost_o);
        end
        mode = ModeAck;
        slave_scl = 1'b0;
        issue(CmdWrite, 8'h44);
        c = -1;
        for (int k = 0; k <= 1000; k++) begin
            if (k == 54) slave_scl = 1'b1;
            if (bif.done_o) begin
                c = k;
                break;
            end
            @(negedge clk);
        end
        slave_scl = 1'b1;
        checks++;
        if (c !== exp_c || bif.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL stretch: got cycles=%0d ack=%b want %0d 1", c, bif.ack_o, exp_c);
        end
        test_stop();
    endtask

    task automatic test_midreset();
        int pulses;
        test_start();
        mode = ModeIdle;
        issue(CmdWrite, 8'h00);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bif.cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ready: got %b want 0", bif.cmd_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bif.scl_o, bif.sda_o, bif.bus_busy_o, bif.done_o} !== 4'b1100) begin
            failures++;
            $display("FAIL midreset_lines: got scl/sda/busy/done=%b want 1100",
                     {bif.scl_o, bif.sda_o, bif.bus_busy_o, bif.done_o});
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bif.done_o) pulses++;
        end
        checks++;
        if (pulses !== 0 || bif.cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_quiet: got done pulses=%0d ready=%b want 0 1", pulses,
                     bif.cmd_ready_o);
        end
    endtask

    initial begin
        bif.cmd_i = 3'b000;
        bif.cmd_valid_i = 1'b0;
        bif.wr_data_i = 8'h00;
        @(negedge clk);
        test_reset();
        test_error();
        test_addr_write();
        test_nack();
        test_read();
        test_arb();
        test_stretch();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
